// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch requester, data requester and the shared memory port.
// The arbiter uses the slave view; the environment (requesters plus memory) uses the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  // Instruction-fetch requester
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ready;

  // Load/store requester
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [3:0]            d_be;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ready;

  // Unified memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store traffic.
// Data accesses win arbitration, but after MAX_DATA_BURST consecutive data grants taken while
// fetch was waiting, fetch is granted once. Each access runs IDLE -> GNT -> DONE, so a
// zero-wait memory sustains one access every three cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_DATA_BURST = 4   // 1..15
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntD, StDone} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_DATA_BURST);

  state_e                state_q, state_d;
  logic [3:0]            streak_q, streak_d;
  logic                  data_owner_q, data_owner_d;  // current/last grant belongs to data path
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic data_wins;

  // Data wins unless fetch is also waiting and the data streak has reached its limit.
  assign data_wins = bus.d_req && (!bus.if_req || (streak_q < MaxBurst));

  // Next-state, arbitration and command/read-data capture.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    data_owner_d = data_owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      StIdle: begin
        if (data_wins) begin
          state_d      = StGntD;
          data_owner_d = 1'b1;
          mem_req_d    = 1'b1;
          mem_we_d     = bus.d_we;
          mem_addr_d   = bus.d_addr;
          mem_wdata_d  = bus.d_wdata;
          mem_be_d     = bus.d_be;
          // The streak only counts data grants that made fetch wait.
          streak_d     = bus.if_req ? (streak_q + 4'd1) : 4'd0;
        end else if (bus.if_req) begin
          state_d      = StGntIf;
          data_owner_d = 1'b0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          mem_be_d     = 4'hF;
          streak_d     = 4'd0;
        end
      end
      StGntIf: begin
        if (bus.mem_ack) begin
          state_d    = StDone;
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata;
        end
      end
      StGntD: begin
        if (bus.mem_ack) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      streak_q     <= 4'd0;
      data_owner_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'h0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      data_owner_q <= data_owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  // Ready pulses are decoded from registered state only, so they last exactly the DONE cycle.
  assign bus.if_ready  = (state_q == StDone) && !data_owner_q;
  assign bus.d_ready   = (state_q == StDone) && data_owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model with its own copy of memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW       = 10;
  localparam int unsigned DW       = 32;
  localparam int          MaxBurst = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MAX_DATA_BURST(MaxBurst)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = 4'h0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_ready,
         bus.d_ready, bus.if_rdata, bus.d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required all zero",
               {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_ready,
                bus.d_ready, bus.if_rdata, bus.d_rdata});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.mem_req, bus.if_ready, bus.d_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got %b required 000", {bus.mem_req, bus.if_ready, bus.d_ready});
    end
  endtask

  task automatic test_single_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h004;
    tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !==
        {1'b1, 1'b0, 10'h004, 4'hF, 32'h0}) begin
      n_fail++;
      $display("FAIL fetch_cmd: got req=%b we=%b addr=%h be=%h wdata=%h required 1 0 004 f 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    end
    tick();
    n_checks++;
    if ({bus.mem_req, bus.if_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_wait: got req/ready=%b required 10", {bus.mem_req, bus.if_ready});
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00500093;
    tick();
    n_checks++;
    if ({bus.if_ready, bus.d_ready, bus.mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL fetch_ready: got %b required 100", {bus.if_ready, bus.d_ready, bus.mem_req});
    end
    n_checks++;
    if (bus.if_rdata !== 32'h00500093) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h required 00500093", bus.if_rdata);
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.if_req    = 1'b0;
    tick();
    n_checks++;
    if ({bus.if_ready, bus.d_ready, bus.mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL fetch_after: got %b required 000", {bus.if_ready, bus.d_ready, bus.mem_req});
    end
  endtask

  task automatic test_store_load();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 10'h010;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'b0011;
    tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !==
        {1'b1, 1'b1, 10'h010, 4'b0011, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL store_cmd: got req=%b we=%b addr=%h be=%h wdata=%h required 1 1 010 3 deadbeef",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++;
    if ({bus.if_ready, bus.d_ready, bus.mem_req} !== 3'b010) begin
      n_fail++;
      $display("FAIL store_ready: got %b required 010", {bus.if_ready, bus.d_ready, bus.mem_req});
    end
    n_checks++;
    if (bus.d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL store_rdata: got %h required 00000000", bus.d_rdata);
    end
    bus.d_req = 1'b0;
    tick();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_be   = 4'hF;
    tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 10'h010}) begin
      n_fail++;
      $display("FAIL load_cmd: got req=%b we=%b addr=%h required 1 0 010",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000BEEF;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++;
    if ({bus.d_ready, bus.d_rdata, bus.if_rdata} !== {1'b1, 32'h0000BEEF, 32'h00500093}) begin
      n_fail++;
      $display("FAIL load_result: got ready=%b d_rdata=%h if_rdata=%h required 1 0000beef 00500093",
               bus.d_ready, bus.d_rdata, bus.if_rdata);
    end
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    bit exp_fetch [10];
    bit got_fetch [$];
    int streak   = 0;
    bit prev_req = 1'b0;
    int cyc      = 0;
    // Both requesters always waiting: data keeps winning until the burst limit is used up.
    for (int i = 0; i < 10; i++) begin
      if (streak < MaxBurst) begin
        exp_fetch[i] = 1'b0;
        streak++;
      end else begin
        exp_fetch[i] = 1'b1;
        streak = 0;
      end
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 10'h200;
    bus.d_be    = 4'hF;
    bus.d_wdata = '0;
    while (got_fetch.size() < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (bus.mem_req && !prev_req) got_fetch.push_back(bus.mem_addr == 10'h100);
      prev_req      = bus.mem_req;
      bus.mem_ack   = bus.mem_req && !bus.mem_ack;
      bus.mem_rdata = (bus.mem_addr == 10'h100) ? 32'h11111111 : 32'h22222222;
    end
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    tick();
    tick();
    n_checks++;
    if (got_fetch.size() != 10) begin
      n_fail++;
      $display("FAIL starve_grant_count: got %0d grants required 10", got_fetch.size());
    end
    for (int i = 0; i < got_fetch.size(); i++) begin
      n_checks++;
      if (got_fetch[i] !== exp_fetch[i]) begin
        n_fail++;
        $display("FAIL starve_order grant %0d: got fetch=%b required fetch=%b",
                 i, got_fetch[i], exp_fetch[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] wd = $urandom();
    logic [3:0]  be = 4'($urandom_range(1, 15));
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 10'h3A5;
    bus.d_wdata = wd;
    bus.d_be    = be;
    for (int c = 1; c <= 6; c++) begin
      tick();
      // Dropping the request mid-grant must not abort the access.
      if (c == 3) bus.d_req = 1'b0;
      n_checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.d_ready} !==
          {1'b1, 1'b1, 10'h3A5, be, wd, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_hold cycle %0d: got req=%b we=%b addr=%h be=%h wdata=%h rdy=%b required 1 1 3a5 %h %h 0",
                 c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                 bus.d_ready, be, wd);
      end
      if (c == 6) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hA5A5A5A5;
      end
    end
    tick();
    bus.mem_ack = 1'b0;
    n_checks++;
    if ({bus.if_ready, bus.d_ready, bus.mem_req, bus.d_rdata} !== {3'b010, 32'h22222222}) begin
      n_fail++;
      $display("FAIL wait_complete: got rdy/req=%b d_rdata=%h required 010 22222222",
               {bus.if_ready, bus.d_ready, bus.mem_req}, bus.d_rdata);
    end
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++;
    if ({bus.if_ready, bus.d_ready, bus.mem_req, bus.if_rdata, bus.d_rdata} !==
        {3'b000, 32'h11111111, 32'h22222222}) begin
      n_fail++;
      $display("FAIL stray_ack: got rdy/req=%b if_rdata=%h d_rdata=%h required 000 11111111 22222222",
               {bus.if_ready, bus.d_ready, bus.mem_req}, bus.if_rdata, bus.d_rdata);
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h0AA;
    tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 10'h0AA}) begin
      n_fail++;
      $display("FAIL stray_then_fetch: got req=%b addr=%h required 1 0aa", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h33333333;
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    n_checks++;
    if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h33333333}) begin
      n_fail++;
      $display("FAIL stray_then_fetch_rdata: got ready=%b rdata=%h required 1 33333333",
               bus.if_ready, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 10'h055;
    bus.d_be   = 4'hF;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_grant: got mem_req=%b required 1", bus.mem_req);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.d_ready, bus.if_rdata, bus.d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: got req=%b rdy=%b if_rdata=%h d_rdata=%h required all zero",
               bus.mem_req, bus.d_ready, bus.if_rdata, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    tick();
    n_checks++;
    if ({bus.if_ready, bus.d_ready, bus.mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL areset_no_ready: got %b required 000", {bus.if_ready, bus.d_ready, bus.mem_req});
    end
    rst_n       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h020;
    tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 10'h020}) begin
      n_fail++;
      $display("FAIL areset_fetch_cmd: got req=%b addr=%h required 1 020", bus.mem_req, bus.mem_addr);
    end
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    n_checks++;
    if ({bus.if_ready, bus.d_ready, bus.if_rdata} !== {2'b10, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL areset_fetch_done: got rdy=%b rdata=%h required 10 cafef00d",
               {bus.if_ready, bus.d_ready}, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int          pulses [$];
    int          cyc  = 0;
    logic [9:0]  addr = 10'h040;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    while (pulses.size() < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.if_ready) begin
        pulses.push_back(cyc);
        n_checks++;
        if ({bus.mem_req, bus.if_rdata} !== {1'b0, 22'h0, addr}) begin
          n_fail++;
          $display("FAIL b2b_done: got mem_req=%b rdata=%h required 0 %h",
                   bus.mem_req, bus.if_rdata, {22'h0, addr});
        end
        addr        = addr + 10'd1;
        bus.if_addr = addr;
      end
      bus.mem_ack   = bus.mem_req && !bus.mem_ack;
      bus.mem_rdata = {22'h0, bus.mem_addr};
    end
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    tick();
    n_checks++;
    if (pulses.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d ready pulses required 6", pulses.size());
    end
    for (int i = 1; i < pulses.size(); i++) begin
      n_checks++;
      if (pulses[i] - pulses[i-1] != 3) begin
        n_fail++;
        $display("FAIL b2b_spacing %0d: got %0d cycles required 3", i, pulses[i] - pulses[i-1]);
      end
    end
  endtask

  // Randomized requesters and a random-latency memory, checked against a transaction model.
  task automatic test_random();
    logic [31:0] model_ram [16];
    logic [31:0] phys_ram  [16];
    int          streak    = 0;
    int          phase     = 0;  // 0: arbiter free, 1: access in flight, 2: completion cycle
    int          resp_wait = 0;
    int          grants    = 0;
    bit          resp_busy = 1'b0;
    bit          win_data  = 1'b0;
    logic        c_we      = 1'b0;
    logic [9:0]  c_addr    = '0;
    logic [3:0]  c_be      = '0;
    logic [31:0] c_wdata   = '0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    logic        p_if_req = 1'b0, p_d_req = 1'b0, p_d_we = 1'b0, p_ack = 1'b0;
    logic [9:0]  p_if_addr = '0, p_d_addr = '0;
    logic [3:0]  p_d_be    = '0;
    logic [31:0] p_d_wdata = '0;
    logic [2:0]  exp_hs;
    logic [3:0]  ra;

    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      model_ram[i] = $urandom();
      phys_ram[i]  = model_ram[i];
    end

    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      // Advance the model over the edge just taken, using the inputs of the previous cycle.
      if (phase == 0) begin
        if (p_if_req || p_d_req) begin
          win_data = p_d_req && (!p_if_req || streak < MaxBurst);
          streak   = (win_data && p_if_req) ? streak + 1 : 0;
          if (win_data) begin
            c_we = p_d_we; c_addr = p_d_addr; c_be = p_d_be; c_wdata = p_d_wdata;
          end else begin
            c_we = 1'b0; c_addr = p_if_addr; c_be = 4'hF; c_wdata = '0;
          end
          phase = 1;
          grants++;
        end
      end else if (phase == 1) begin
        if (p_ack) begin
          phase = 2;
          if (!win_data) exp_if_rdata = model_ram[c_addr[3:0]];
          else if (!c_we) exp_d_rdata = model_ram[c_addr[3:0]];
          else begin
            for (int b = 0; b < 4; b++)
              if (c_be[b]) model_ram[c_addr[3:0]][8*b +: 8] = c_wdata[8*b +: 8];
          end
        end
      end else begin
        phase = 0;
      end

      exp_hs = {phase == 1, phase == 2 && !win_data, phase == 2 && win_data};
      n_checks++;
      if ({bus.mem_req, bus.if_ready, bus.d_ready} !== exp_hs) begin
        n_fail++;
        $display("FAIL rnd_handshake cyc %0d: got req/if_rdy/d_rdy=%b required %b",
                 cyc, {bus.mem_req, bus.if_ready, bus.d_ready}, exp_hs);
      end
      if (phase == 1) begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {c_we, c_addr, c_be, c_wdata}) begin
          n_fail++;
          $display("FAIL rnd_cmd cyc %0d: got we=%b addr=%h be=%h wdata=%h required %b %h %h %h",
                   cyc, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                   c_we, c_addr, c_be, c_wdata);
        end
      end
      n_checks++;
      if ({bus.if_rdata, bus.d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin
        n_fail++;
        $display("FAIL rnd_rdata cyc %0d: got if=%h d=%h required if=%h d=%h",
                 cyc, bus.if_rdata, bus.d_rdata, exp_if_rdata, exp_d_rdata);
      end

      // Memory: random wait states while requested, occasional stray acks otherwise.
      if (bus.mem_req) begin
        if (!resp_busy) begin
          resp_busy = 1'b1;
          resp_wait = $urandom_range(0, 3);
        end
        if (resp_wait == 0) begin
          resp_busy   = 1'b0;
          bus.mem_ack = 1'b1;
          ra          = bus.mem_addr[3:0];
          if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_be[b]) phys_ram[ra][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            bus.mem_rdata = $urandom();
          end else begin
            bus.mem_rdata = phys_ram[ra];
          end
        end else begin
          resp_wait--;
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom();
        end
      end else begin
        bus.mem_ack   = ($urandom_range(0, 7) == 0);
        bus.mem_rdata = $urandom();
      end

      // Requesters hold each request until its ready pulse, then may re-issue at once.
      if (bus.if_ready) bus.if_req = 1'b0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = 10'($urandom_range(0, 15));
      end
      if (bus.d_ready) bus.d_req = 1'b0;
      if (!bus.d_req && $urandom_range(0, 1) == 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = 10'($urandom_range(0, 15));
        bus.d_be    = 4'($urandom());
        bus.d_wdata = $urandom();
      end

      p_if_req  = bus.if_req;
      p_if_addr = bus.if_addr;
      p_d_req   = bus.d_req;
      p_d_we    = bus.d_we;
      p_d_addr  = bus.d_addr;
      p_d_be    = bus.d_be;
      p_d_wdata = bus.d_wdata;
      p_ack     = bus.mem_ack;
    end
    n_checks++;
    if (grants < 100) begin
      n_fail++;
      $display("FAIL rnd_grant_count: got %0d grants required at least 100", grants);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_starvation();
    test_wait_states();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
